// File: rtl/pulse_checker.sv
// Measures high time and rise-to-rise period of a pulse train against expected values,
// reporting per-measurement errors, lock after a run of clean periods, and rise timeout.
module pulse_checker #(
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned EXP_DURATION = 3,
    parameter int unsigned EXP_PERIOD   = 7,
    parameter int unsigned TOLERANCE    = 0,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pulse,
    output logic [CNT_WIDTH-1:0] o_duration,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic                 o_valid,
    output logic                 o_err_duration,
    output logic                 o_err_period,
    output logic                 o_locked,
    output logic                 o_timeout
);

    localparam int unsigned CW1 = CNT_WIDTH + 1;
    localparam int unsigned LCW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        StSync,
        StArm,
        StMeas
    } state_e;

    state_e               state_q, state_d;
    logic                 s_q, s_qq;
    logic                 rise, fall;
    logic [CNT_WIDTH-1:0] per_cnt_q, hi_cnt_q, hi_lat_q;
    logic                 fall_seen_q;
    logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
    logic [CNT_WIDTH-1:0] meas_dur;
    logic                 err_dur, err_per;
    logic                 take_meas, timeout_hit;

    // Absolute difference is taken one bit wider so the subtraction can never wrap.
    function automatic logic out_of_tol(input logic [CNT_WIDTH-1:0] meas,
                                        input int unsigned expv);
        logic [CNT_WIDTH:0] m, e, d;
        m = {1'b0, meas};
        e = CW1'(expv);
        d = (m > e) ? (m - e) : (e - m);
        return d > CW1'(TOLERANCE);
    endfunction

    assign rise     = s_q & ~s_qq;
    assign fall     = ~s_q & s_qq;
    assign meas_dur = fall_seen_q ? hi_lat_q : hi_cnt_q;
    assign err_dur  = out_of_tol(meas_dur, EXP_DURATION);
    assign err_per  = out_of_tol(per_cnt_q, EXP_PERIOD);

    always_comb begin
        state_d     = state_q;
        take_meas   = 1'b0;
        timeout_hit = 1'b0;
        lock_cnt_d  = lock_cnt_q;
        case (state_q)
            StSync: if (!s_q) state_d = StArm;
            StArm:  if (rise) state_d = StMeas;
            StMeas: begin
                if (rise) begin
                    take_meas = 1'b1;
                end else if (per_cnt_q == CNT_WIDTH'(TIMEOUT)) begin
                    state_d     = StArm;
                    timeout_hit = 1'b1;
                end
            end
            default: state_d = StSync;
        endcase

        if (timeout_hit) begin
            lock_cnt_d = '0;
        end else if (take_meas) begin
            if (err_dur || err_per) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LCW'(LOCK_COUNT)) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= StSync;
            s_q            <= 1'b0;
            s_qq           <= 1'b0;
            per_cnt_q      <= '0;
            hi_cnt_q       <= '0;
            hi_lat_q       <= '0;
            fall_seen_q    <= 1'b0;
            lock_cnt_q     <= '0;
            o_duration     <= '0;
            o_period       <= '0;
            o_valid        <= 1'b0;
            o_err_duration <= 1'b0;
            o_err_period   <= 1'b0;
            o_locked       <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= i_pulse;
            s_qq       <= s_q;
            lock_cnt_q <= lock_cnt_d;

            if (rise) begin
                per_cnt_q <= CNT_WIDTH'(1);
            end else if (!(&per_cnt_q)) begin
                per_cnt_q <= per_cnt_q + 1'b1;
            end

            if (rise) begin
                hi_cnt_q <= CNT_WIDTH'(1);
            end else if (s_q && !(&hi_cnt_q)) begin
                hi_cnt_q <= hi_cnt_q + 1'b1;
            end

            if (fall) hi_lat_q <= hi_cnt_q;
            if (rise) begin
                fall_seen_q <= 1'b0;
            end else if (fall) begin
                fall_seen_q <= 1'b1;
            end

            o_valid        <= take_meas;
            o_err_duration <= take_meas & err_dur;
            o_err_period   <= take_meas & err_per;
            if (take_meas) begin
                o_duration <= meas_dur;
                o_period   <= per_cnt_q;
            end
            o_locked <= (lock_cnt_d == LCW'(LOCK_COUNT));

            if (timeout_hit) begin
                o_timeout <= 1'b1;
            end else if (state_q == StArm && rise) begin
                o_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_checker.sv
// Bench for pulse_checker: scripted and random pulse trains compared every cycle against a
// timestamp-based reference model of the measurement rules.
module tb_pulse_checker;

    localparam int unsigned CW       = 16;
    localparam int unsigned EXP_DUR  = 3;
    localparam int unsigned EXP_PER  = 7;
    localparam int unsigned TOL      = 1;
    localparam int unsigned LOCK_N   = 4;
    localparam int unsigned TMO      = 64;
    localparam longint      CMAX     = (64'd1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse;
    logic [CW-1:0] duration, period;
    logic          valid, err_duration, err_period, locked, timeout;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pulse_checker #(
        .CNT_WIDTH   (CW),
        .EXP_DURATION(EXP_DUR),
        .EXP_PERIOD  (EXP_PER),
        .TOLERANCE   (TOL),
        .LOCK_COUNT  (LOCK_N),
        .TIMEOUT     (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pulse       (pulse),
        .o_duration    (duration),
        .o_period      (period),
        .o_valid       (valid),
        .o_err_duration(err_duration),
        .o_err_period  (err_period),
        .o_locked      (locked),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: events are timestamped by cycle index, measurements are differences.
    typedef enum {MSync, MArm, MMeas} mode_t;
    mode_t  m_mode = MSync;
    logic   m_q = 1'b0, m_qq = 1'b0;
    longint cyc = 0, rise_c = 0, fall_c = -1;
    int     clean_run = 0;
    longint e_dur = 0, e_per = 0;
    logic   e_valid = 0, e_ed = 0, e_ep = 0, e_locked = 0, e_timeout = 0;
    int     n_valid_seen = 0;

    function automatic longint absdiff(input longint a, input longint b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_edge(input logic v, input logic r);
        logic rise, fall;
        if (r) begin
            m_mode = MSync; m_q = 0; m_qq = 0; clean_run = 0;
            e_dur = 0; e_per = 0; e_valid = 0; e_ed = 0; e_ep = 0;
            e_locked = 0; e_timeout = 0;
            cyc++;
            return;
        end
        rise = m_q & ~m_qq;
        fall = ~m_q & m_qq;
        e_valid = 0; e_ed = 0; e_ep = 0;
        case (m_mode)
            MSync: if (!m_q) m_mode = MArm;
            MArm: if (rise) begin
                m_mode = MMeas; e_timeout = 0; rise_c = cyc;
            end
            MMeas: begin
                if (rise) begin
                    e_per = sat(cyc - rise_c);
                    e_dur = sat((fall_c > rise_c) ? fall_c - rise_c : cyc - rise_c);
                    e_valid = 1;
                    e_ed = absdiff(e_dur, EXP_DUR) > TOL;
                    e_ep = absdiff(e_per, EXP_PER) > TOL;
                    if (e_ed || e_ep) clean_run = 0;
                    else if (clean_run < LOCK_N) clean_run++;
                    e_locked = (clean_run == LOCK_N);
                    rise_c = cyc;
                end else if (cyc - rise_c == TMO) begin
                    m_mode = MArm; e_timeout = 1; clean_run = 0; e_locked = 0;
                end
            end
            default: m_mode = MSync;
        endcase
        if (fall) fall_c = cyc;
        m_qq = m_q;
        m_q  = v;
        cyc++;
    endtask

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic r);
        pulse = v;
        rst   = r;
        @(posedge clk);
        model_edge(v, r);
        @(negedge clk);
        check_eq("valid", valid, e_valid);
        check_eq("err_duration", err_duration, e_ed);
        check_eq("err_period", err_period, e_ep);
        check_eq("locked", locked, e_locked);
        check_eq("timeout", timeout, e_timeout);
        check_eq("duration", duration, e_dur);
        check_eq("period", period, e_per);
        if (valid) n_valid_seen++;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < hi; j++) step(1'b1, 1'b0);
            for (int j = 0; j < lo; j++) step(1'b0, 1'b0);
        end
    endtask

    initial begin
        pulse = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1);

        // Nominal train, lock acquisition.
        pulses(8, 3, 4);
        check_eq("locked_after_nominal", locked, 1);
        // Stretched period, then relock.
        pulses(1, 3, 6);
        pulses(6, 3, 4);
        // Duration 4 is within tolerance, 5 is not.
        pulses(2, 4, 3);
        pulses(1, 5, 2);
        pulses(5, 3, 4);
        // Input stops low long enough to time out, then resumes.
        pulses(1, 3, 70);
        check_eq("timeout_seen", timeout, 1);
        pulses(6, 3, 4);
        // Reset mid-high while locked.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("reset_clears_locked", locked, 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        pulses(1, 0, 4);
        pulses(6, 3, 4);
        // Input held high through reset release.
        for (int j = 0; j < 3; j++) step(1'b1, 1'b1);
        for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
        pulses(1, 0, 4);
        pulses(6, 3, 4);
        // Stuck-high input times out.
        pulses(1, 80, 4);
        pulses(6, 3, 4);

        // Random mix of nominal, jittered, long-gap and reset segments.
        for (int s = 0; s < 300; s++) begin
            int unsigned sel;
            sel = $urandom_range(0, 99);
            if (sel < 50)      pulses(1, 3, 4);
            else if (sel < 85) pulses(1, $urandom_range(1, 6), $urandom_range(1, 8));
            else if (sel < 92) pulses(1, $urandom_range(1, 4), $urandom_range(60, 70));
            else if (sel < 96) pulses(1, $urandom_range(60, 70), $urandom_range(1, 4));
            else begin
                step(1'($urandom_range(0, 1)), 1'b1);
            end
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        check_eq("strobes_observed_nonzero", (n_valid_seen > 50) ? 1 : 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
